// File: rtl/lsu_bus_fabric.sv
// lsu_bus_fabric: routes one CPU load/store at a time to an addr[31:24]-decoded slave,
// with byte lanes, load formatting, wait states and typed exceptions.
module lsu_bus_fabric #(
    parameter int N_SLAVES = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  en,
    input  logic [31:0]           addr,
    input  logic [31:0]           data_in,
    input  logic                  wr,
    input  logic [2:0]            size,
    output logic [31:0]           data_out,
    output logic                  done,
    output logic                  busy,
    output logic                  exception_out,
    output logic [1:0]            exc_cause,
    output logic [N_SLAVES-1:0]   s_sel,
    output logic [31:0]           s_addr,
    output logic [31:0]           s_wdata,
    output logic [3:0]            s_be,
    output logic                  s_wr,
    input  logic [N_SLAVES*32-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]   s_ready
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_dout;
    logic [2:0] r_size;
    logic r_wr;
    logic [3:0] r_be;
    logic [N_SLAVES-1:0] r_sel;
    logic [1:0] r_cause;
    logic [7:0] r_cnt;
    logic w_bad, w_unmap, w_rdy, w_tmo;
    logic [31:0] w_slice, w_raw, w_fmt, w_wdata;
    logic [3:0] w_be;
    assign w_bad = (size == 3'd3) | (size[2:1] == 2'b11) |
                   ((size[1:0] == 2'd1) & addr[0]) | ((size[1:0] == 2'd2) & (addr[1:0] != 2'd0));
    assign w_unmap = {24'd0, addr[31:24]} >= 32'(N_SLAVES);
    assign w_rdy = |(r_sel & s_ready);
    assign w_tmo = r_cnt == 8'(TIMEOUT - 1);
    assign w_wdata = size[1:0] == 2'd0 ? {4{data_in[7:0]}} :
                     size[1:0] == 2'd1 ? {2{data_in[15:0]}} : data_in;
    assign w_be = !wr ? 4'h0 :
                  size[1:0] == 2'd0 ? 4'b0001 << addr[1:0] :
                  size[1:0] == 2'd1 ? 4'b0011 << addr[1:0] : 4'hF;
    always_comb begin
        w_slice = '0;
        for (int i = 0; i < N_SLAVES; i++)
            w_slice = w_slice | (r_sel[i] ? s_rdata[32*i +: 32] : 32'd0);
    end
    // size[2] marks the unsigned loads, which suppress sign extension
    assign w_raw = w_slice >> {r_addr[1:0], 3'b000};
    assign w_fmt = r_size[1:0] == 2'd2 ? w_raw :
                   r_size[1:0] == 2'd1 ? {{16{w_raw[15] & ~r_size[2]}}, w_raw[15:0]} :
                                         {{24{w_raw[7] & ~r_size[2]}}, w_raw[7:0]};
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !en ? IDLE : (w_bad | w_unmap) ? DONE : ACCESS;
            ACCESS:  w_next = (w_rdy | w_tmo) ? DONE : ACCESS;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_dout  <= '0;
            r_size  <= '0;
            r_wr    <= 1'b0;
            r_be    <= '0;
            r_sel   <= '0;
            r_cause <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && en) begin
                r_addr  <= addr;
                r_wdata <= w_wdata;
                r_size  <= size;
                r_wr    <= wr;
                r_be    <= w_be;
                r_cnt   <= '0;
                r_cause <= w_bad ? 2'd1 : w_unmap ? 2'd2 : 2'd0;
                r_sel   <= (w_bad | w_unmap) ? '0 : N_SLAVES'(1) << addr[31:24];
            end else if (r_state == ACCESS) begin
                if (w_rdy) begin
                    if (!r_wr) r_dout <= w_fmt;
                end else if (w_tmo) begin
                    r_cause <= 2'd3;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end
    assign done          = r_state == DONE;
    assign busy          = r_state != IDLE;
    assign exception_out = done & (r_cause != 2'd0);
    assign exc_cause     = done ? r_cause : 2'd0;
    assign s_sel         = r_state == ACCESS ? r_sel : '0;
    assign s_addr        = r_addr;
    assign s_wdata       = r_wdata;
    assign s_be          = r_be;
    assign s_wr          = r_wr;
    assign data_out      = r_dout;
endmodule

// File: tb/tb_lsu_bus_fabric.sv
// tb_lsu_bus_fabric: scoreboard bench for lsu_bus_fabric with a wait-state slave model.
module tb_lsu_bus_fabric;
    logic CLK = 1'b0, reset = 1'b1, en = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, data_in = '0;
    logic [2:0] size = '0;
    logic [31:0] data_out, s_addr, s_wdata;
    logic done, busy, exception_out, s_wr;
    logic [1:0] exc_cause;
    logic [3:0] s_sel, s_be, s_ready;
    logic [127:0] s_rdata = '0;
    int wait_n = 0, acc_cyc = 0, cyc = 0, n_chk = 0, n_fail = 0;
    typedef struct {
        logic [31:0] dout;
        logic [1:0]  cause;
        int          t_due;
        logic [3:0]  sel;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        wr;
    } exp_t;
    exp_t q[$];
    exp_t e;

    lsu_bus_fabric #(.N_SLAVES(4), .TIMEOUT(8)) dut (
        .CLK(CLK), .reset(reset), .en(en), .addr(addr), .data_in(data_in), .wr(wr),
        .size(size), .data_out(data_out), .done(done), .busy(busy),
        .exception_out(exception_out), .exc_cause(exc_cause), .s_sel(s_sel),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be), .s_wr(s_wr),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 CLK = ~CLK;
    // slave becomes ready after wait_n cycles of being selected
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        acc_cyc <= (|s_sel) ? acc_cyc + 1 : 0;
    end
    assign s_ready = (acc_cyc >= wait_n) ? 4'hF : 4'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    always @(negedge CLK) begin
        if (!reset) begin
            if (done) begin
                if (q.size() == 0) chk("spurious_done", 32'(done), 32'd0);
                else begin
                    e = q.pop_front();
                    chk("data_out", data_out, e.dout);
                    chk("exception_out", 32'(exception_out), 32'(e.cause != 2'd0));
                    chk("exc_cause", 32'(exc_cause), 32'(e.cause));
                    chk("latency", 32'(cyc), 32'(e.t_due));
                    chk("sel_at_done", 32'(s_sel), 32'd0);
                end
            end else begin
                chk("exc_idle", {29'd0, exception_out, exc_cause}, 32'd0);
                if (busy && q.size() > 0) begin
                    chk("s_sel", 32'(s_sel), 32'(q[0].sel));
                    chk("s_be", 32'(s_be), 32'(q[0].be));
                    chk("s_wdata", s_wdata, q[0].wdata);
                    chk("s_wr", 32'(s_wr), 32'(q[0].wr));
                end
            end
        end
    end

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [2:0] sz, input int wn, input logic [31:0] rd, input int slot,
                       input logic [31:0] edout, input logic [1:0] ecause, input int lat,
                       input logic [3:0] esel, input logic [3:0] ebe, input logic [31:0] ewd);
        exp_t x;
        @(negedge CLK);
        addr = a; data_in = d; wr = w; size = sz; wait_n = wn;
        s_rdata = {4{32'h5A5A5A5A}};
        s_rdata[32*slot +: 32] = rd;
        en = 1'b1;
        x = '{edout, ecause, cyc + lat, esel, ebe, ewd, w};
        q.push_back(x);
        @(negedge CLK);
        en = 1'b0;
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge CLK);
        if (q.size() > 0) begin
            chk("done_wait", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel", 32'(s_sel), 32'd0);
        chk("rst_be", 32'(s_be), 32'd0);
        chk("rst_wr", 32'(s_wr), 32'd0);
        chk("rst_dout", data_out, 32'd0);
        chk("rst_exc", {29'd0, exception_out, exc_cause}, 32'd0);
        req(32'h0100_0004, 0, 0, 3'd2, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 2, 4'b0010, 4'h0, 0);
        req(32'h0100_0003, 0, 0, 3'd0, 0, 32'h80112233, 1, 32'hFFFFFF80, 0, 2, 4'b0010, 4'h0, 0);
        req(32'h0100_0003, 0, 0, 3'd4, 1, 32'h80112233, 1, 32'h00000080, 0, 3, 4'b0010, 4'h0, 0);
        req(32'h0100_0002, 0, 0, 3'd5, 0, 32'h80112233, 1, 32'h00008011, 0, 2, 4'b0010, 4'h0, 0);
        req(32'h0100_0002, 0, 0, 3'd1, 0, 32'h80112233, 1, 32'hFFFF8011, 0, 2, 4'b0010, 4'h0, 0);
        req(32'h0200_0002, 32'h0000ABCD, 1, 3'd1, 2, 32'h11111111, 2, 32'hFFFF8011, 0, 4,
            4'b0100, 4'b1100, 32'hABCDABCD);
        req(32'h0300_0001, 32'h123456A5, 1, 3'd0, 1, 32'h22222222, 3, 32'hFFFF8011, 0, 3,
            4'b1000, 4'b0010, 32'hA5A5A5A5);
        req(32'h0000_0000, 32'h12345678, 1, 3'd2, 0, 32'h33333333, 0, 32'hFFFF8011, 0, 2,
            4'b0001, 4'hF, 32'h12345678);
        req(32'h0000_0002, 0, 0, 3'd2, 0, 32'h44444444, 0, 32'hFFFF8011, 1, 1, 4'h0, 4'h0, 0);
        req(32'h0500_0000, 0, 0, 3'd2, 0, 32'h44444444, 0, 32'hFFFF8011, 2, 1, 4'h0, 4'h0, 0);
        req(32'h0500_0001, 0, 0, 3'd1, 0, 32'h44444444, 0, 32'hFFFF8011, 1, 1, 4'h0, 4'h0, 0);
        req(32'h0100_0000, 0, 0, 3'd3, 0, 32'h44444444, 1, 32'hFFFF8011, 1, 1, 4'h0, 4'h0, 0);
        req(32'h0300_0000, 0, 0, 3'd2, 1000, 32'h55555555, 3, 32'hFFFF8011, 3, 9, 4'b1000, 4'h0, 0);
        req(32'h0300_0000, 0, 0, 3'd2, 7, 32'hCAFEF00D, 3, 32'hCAFEF00D, 0, 9, 4'b1000, 4'h0, 0);
        @(negedge CLK);
        addr = 32'h0100_0000; wr = 1'b0; size = 3'd2; wait_n = 5; en = 1'b1;
        @(negedge CLK);
        en = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        chk("abort_sel", 32'(s_sel), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dout", data_out, 32'd0);
        repeat (8) @(negedge CLK);
        req(32'h0200_0008, 0, 0, 3'd2, 0, 32'h13579BDF, 2, 32'h13579BDF, 0, 2, 4'b0100, 4'h0, 0);
        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu_bus_fabric.md
Name: lsu_bus_fabric

Overview:
- Parametrised successor to the CPU load/store decoder.
- Routes one CPU memory request at a time to one of N_SLAVES memory-mapped regions, selected by addr[31:24].
- Adds what the flat decoder lacks: registered request/done handshake, byte-lane enables, write-data replication, read-data alignment with sign/zero extension, variable slave wait states, and a typed exception on misaligned, unmapped or timed-out accesses.

Parameters:
- N_SLAVES, 4: number of slave ports. Slave i owns addr[31:24] == i.
- TIMEOUT, 255: maximum cycles spent in ACCESS before a timeout exception. Range 1..255.

Ports:
- CLK  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  request strobe; sampled only in IDLE.
- addr  input  32  byte address.
- data_in  input  32  store data, right-justified.
- wr  input  1  1 = store, 0 = load.
- size  input  3  RISC-V funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU; 3, 6, 7 are illegal.
- data_out  output  32  formatted load result; held until the next load completes.
- done  output  1  one-cycle pulse when the request completes, with or without error.
- busy  output  1  high whenever state != IDLE.
- exception_out  output  1  valid with done; 1 = access failed.
- exc_cause  output  2  0 none, 1 misaligned or illegal size, 2 unmapped region, 3 timeout.
- s_sel  output  N_SLAVES  one-hot slave select, held for the whole access.
- s_addr  output  32  latched request address.
- s_wdata  output  32  lane-replicated store data.
- s_be  output  4  byte enables; 0 for loads.
- s_wr  output  1  latched wr.
- s_rdata  input  N_SLAVES*32  slave i read data at bits [32i+31:32i].
- s_ready  input  N_SLAVES  slave i completes the access in any cycle it sees s_sel[i] & s_ready[i].

Behaviour:
- Reset values: state IDLE; s_sel=0, s_be=0, s_wr=0; done=0, busy=0, exception_out=0, exc_cause=0; data_out=0; timeout counter=0.
- Reset mid-access: same values on the next edge; the access is abandoned with no done and no exception.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - On en=1, latch addr, data_in, wr, size; compute checks.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or illegal size -> DONE, cause 1.
  - Else addr[31:24] >= N_SLAVES -> DONE, cause 2.
  - Cause 1 takes priority over cause 2.
  - Else -> ACCESS with s_sel[addr[31:24]]=1 and counter cleared.
  - en=0 -> stay in IDLE.
- ACCESS:
  - s_sel, s_addr, s_wdata, s_be, s_wr are stable.
  - Selected s_ready=1 -> DONE; on a load, latch the formatted read into data_out.
  - Else counter increments. When the counter == TIMEOUT-1 and ready is still low -> DONE, cause 3.
  - Ready in the same cycle as the timeout edge wins; no exception.
- DONE:
  - done=1 for exactly one cycle; exception_out = (cause != 0); s_sel=0; next state IDLE.
  - exception_out and exc_cause are valid only while done=1 and read 0 otherwise.
- Latency from en accepted to done: 1 cycle on an error in IDLE; 2 + wait cycles on a normal access. A zero-wait slave gives done 2 cycles after en.
- en while busy is ignored, not queued. The CPU must re-present the request after done.
- Store lanes:
  - SB: s_be = 4'b0001 << addr[1:0]; s_wdata = the byte replicated 4x.
  - SH: s_be = 4'b0011 << addr[1:0]; s_wdata = the half replicated 2x.
  - SW: s_be = 4'hF; s_wdata = data_in.
- Load formatting:
  - raw = s_rdata slice >> (8*addr[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - A failed load does not update data_out.
- A store never updates data_out.
- No slave sees s_sel on a failed request.

Test Plan:
- LW from 0x0100_0004, slave 1 ready immediately with 0xDEADBEEF -> done 2 cycles after en; data_out=0xDEADBEEF; exception_out=0.
- LB at 0x0100_0003 with rdata 0x80112233 -> data_out=0xFFFFFF80. The same access as LBU -> 0x00000080. LHU at 0x0100_0002 -> 0x00008011.
- SH of data_in 0x0000ABCD at 0x0200_0002 -> s_sel=4'b0100, s_be=4'b1100, s_wdata=0xABCDABCD, s_wr=1; data_out unchanged.
- LW at 0x0000_0002 -> done the cycle after en, cause 1, s_sel never asserted. LW at 0x0500_0000 with N_SLAVES=4 -> cause 2.
- TIMEOUT=8, slave 3 never ready -> done 9 cycles after en with cause 3. Repeat with ready asserted on the final wait cycle -> no exception.
- reset asserted 2 cycles into a 5-wait-state access -> next cycle s_sel=0, busy=0, no done pulse. A new request then completes normally.
